// File: rtl/controlador_pkg.sv
// Shared types for the register-control sequencer: register control codes,
// ULA select codes, command codes and the FSM state encoding.
package controlador_pkg;

    typedef enum logic [3:0] {
        CLEAR = 4'd0,
        HOLD  = 4'd1,
        LOAD  = 4'd2,
        SHFTR = 4'd3
    } reg_code_t;

    typedef enum logic [2:0] {
        PASS_IN = 3'd0,
        ADD     = 3'd1,
        SUB     = 3'd2,
        INC_Z   = 3'd3
    } ula_sel_t;

    typedef enum logic [1:0] {
        OP_ADD    = 2'd0,
        OP_SUB    = 2'd1,
        OP_POPCNT = 2'd2,
        OP_CLRALL = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LDX   = 3'd1,
        LDY   = 3'd2,
        EXEC  = 3'd3,
        CLRZ  = 3'd4,
        CONTA = 3'd5,
        CLR   = 3'd6,
        FIM   = 3'd7
    } state_t;

    // ULA operation used in EXEC; only ADD and SUB commands reach that state.
    function automatic ula_sel_t ula_for_op(input op_t op);
        return (op == OP_SUB) ? SUB : ADD;
    endfunction

endpackage

// File: rtl/controlador_registradores_if.sv
// Command/control bundle between the command source + datapath (master)
// and the register sequencer (slave).
// Handshake: start is a request level sampled only while the controller is
// in IDLE (busy=0); the command is accepted on that edge and op is latched.
// Any start seen while busy=1 is dropped, never queued. done pulses for one
// cycle when the command completes; busy stays high from the cycle after
// acceptance through the done cycle.
// Optional macro CONTROLADOR_ABORT_EN adds abort (in) / aborted (out).
interface controlador_registradores_if;
    import controlador_pkg::*;

    logic       start;
    logic [1:0] op;
    logic       y_lsb;
    logic [3:0] Tx;
    logic [3:0] Ty;
    logic [3:0] Tz;
    logic [2:0] sel_ula;
    logic       sel_in;
    logic       busy;
    logic       done;
    state_t     state;   // debug view of the sequencer state
`ifdef CONTROLADOR_ABORT_EN
    logic       abort;
    logic       aborted;

    modport master (
        output start, op, y_lsb, abort,
        input  Tx, Ty, Tz, sel_ula, sel_in, busy, done, state, aborted
    );

    modport slave (
        input  start, op, y_lsb, abort,
        output Tx, Ty, Tz, sel_ula, sel_in, busy, done, state, aborted
    );
`else
    modport master (
        output start, op, y_lsb,
        input  Tx, Ty, Tz, sel_ula, sel_in, busy, done, state
    );

    modport slave (
        input  start, op, y_lsb,
        output Tx, Ty, Tz, sel_ula, sel_in, busy, done, state
    );
`endif
endinterface

// File: rtl/contador_iteracoes.sv
// Iteration counter for the POPCNT loop: synchronous clear, count enable,
// terminal-count flag raised on the last of WIDTH iterations.
module contador_iteracoes #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CNT_W-1:0] count;

    // Count register: reset and clear both return to zero.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // Terminal count marks the final iteration so the FSM can leave on it.
    always_comb begin
        tc = (count == CNT_W'(WIDTH - 1));
    end

endmodule

// File: rtl/controlador_registradores.sv
// Sequencer driving the X/Y/Z register control codes and the ULA/operand
// selects for ADD, SUB, POPCNT and CLRALL commands. Owns no data.
// Optional macro CONTROLADOR_ABORT_EN: abort input returns to IDLE from any
// working state, forcing HOLD outputs and pulsing aborted for that cycle.
module controlador_registradores
    import controlador_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    controlador_registradores_if.slave  bus
);

    state_t state;
    state_t next_state;
    op_t    op_q;
    logic   tc;
    logic   cnt_enable;

`ifdef CONTROLADOR_ABORT_EN
    logic abort_hit;
    assign abort_hit = bus.abort && (state != IDLE) && (state != FIM);
    assign cnt_enable = (state == CONTA) && !abort_hit;
`else
    assign cnt_enable = (state == CONTA);
`endif

    contador_iteracoes #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_contador (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == CLRZ),
        .enable (cnt_enable),
        .tc     (tc)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Command latch: op is captured only on the accepting edge in IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q <= OP_ADD;
        end else if ((state == IDLE) && bus.start) begin
            op_q <= op_t'(bus.op);
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = (op_t'(bus.op) == OP_CLRALL) ? CLR : LDX;
            LDX:     next_state = LDY;
            LDY:     next_state = (op_q == OP_POPCNT) ? CLRZ : EXEC;
            EXEC:    next_state = FIM;
            CLRZ:    next_state = CONTA;
            CONTA:   if (tc) next_state = FIM;
            CLR:     next_state = FIM;
            FIM:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
`ifdef CONTROLADOR_ABORT_EN
        if (abort_hit) next_state = IDLE;
`endif
    end

    // Output decode: Moore on state, except Tz in CONTA follows y_lsb.
    always_comb begin
        bus.Tx      = HOLD;
        bus.Ty      = HOLD;
        bus.Tz      = HOLD;
        bus.sel_ula = PASS_IN;
        bus.sel_in  = 1'b0;
        bus.done    = 1'b0;
        bus.busy    = (state != IDLE);
        bus.state   = state;
        case (state)
            LDX: begin
                bus.Tx = LOAD;
            end
            LDY: begin
                bus.Ty     = LOAD;
                bus.sel_in = 1'b1;
            end
            EXEC: begin
                bus.Tz      = LOAD;
                bus.sel_ula = ula_for_op(op_q);
            end
            CLRZ: begin
                bus.Tz = CLEAR;
            end
            CONTA: begin
                bus.Ty      = SHFTR;
                bus.sel_ula = INC_Z;
                bus.Tz      = bus.y_lsb ? LOAD : HOLD;
            end
            CLR: begin
                bus.Tx = CLEAR;
                bus.Ty = CLEAR;
                bus.Tz = CLEAR;
            end
            FIM: begin
                bus.done = 1'b1;
            end
            default: ;
        endcase
`ifdef CONTROLADOR_ABORT_EN
        bus.aborted = abort_hit;
        if (abort_hit) begin
            bus.Tx      = HOLD;
            bus.Ty      = HOLD;
            bus.Tz      = HOLD;
            bus.sel_ula = PASS_IN;
            bus.sel_in  = 1'b0;
            bus.done    = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_controlador_registradores.sv
// Directed bench for controlador_registradores with a small register/ULA
// datapath model attached so command results can be checked end to end.
module tb_controlador_registradores;

    localparam logic [3:0] K_CLR = 4'd0;
    localparam logic [3:0] K_HLD = 4'd1;
    localparam logic [3:0] K_LD  = 4'd2;
    localparam logic [3:0] K_SHR = 4'd3;
    localparam logic [2:0] U_PASS = 3'd0;
    localparam logic [2:0] U_ADD  = 3'd1;
    localparam logic [2:0] U_SUB  = 3'd2;
    localparam logic [2:0] U_INC  = 3'd3;

    logic clock = 1'b0;
    logic reset;
    int   n_compared = 0;
    int   n_mismatched = 0;

    logic [3:0] operand_a = 4'd0;
    logic [3:0] operand_b = 4'd0;
    logic [3:0] x_reg = 4'd0;
    logic [3:0] y_reg = 4'd0;
    logic [3:0] z_reg = 4'd0;
    logic [3:0] ula_in;
    logic [3:0] ula_out;

    controlador_registradores_if bus();

    controlador_registradores #(.WIDTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    always #5 clock = ~clock;

    // Datapath model: operand mux, ULA, and X/Y/Z registers.
    assign bus.y_lsb = y_reg[0];
    always_comb ula_in = bus.sel_in ? operand_b : operand_a;
    always_comb begin
        case (bus.sel_ula)
            3'd1:    ula_out = x_reg + y_reg;
            3'd2:    ula_out = x_reg - y_reg;
            3'd3:    ula_out = z_reg + 4'd1;
            default: ula_out = ula_in;
        endcase
    end

    function automatic logic [3:0] reg_next(input logic [3:0] code, input logic [3:0] cur);
        case (code)
            4'd0:    return 4'd0;
            4'd2:    return ula_out;
            4'd3:    return cur >> 1;
            default: return cur;
        endcase
    endfunction

    always @(posedge clock) begin
        x_reg <= reg_next(bus.Tx, x_reg);
        y_reg <= reg_next(bus.Ty, y_reg);
        z_reg <= reg_next(bus.Tz, z_reg);
    end

    function automatic logic [17:0] outs();
        return {bus.Tx, bus.Ty, bus.Tz, bus.sel_ula, bus.sel_in, bus.busy, bus.done};
    endfunction

    function automatic logic [17:0] exp_v(input logic [3:0] tx, input logic [3:0] ty,
                                          input logic [3:0] tz, input logic [2:0] su,
                                          input logic si, input logic b, input logic d);
        return {tx, ty, tz, su, si, b, d};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] idle_v;
        idle_v = exp_v(K_HLD, K_HLD, K_HLD, U_PASS, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'd0;
        step();
        step();
        n_compared++;
        if (outs() !== idle_v) begin
            n_mismatched++;
            $display("FAIL reset_outputs: got %h expected %h", outs(), idle_v);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_compared++;
            if (outs() !== idle_v) begin
                n_mismatched++;
                $display("FAIL idle_hold[%0d]: got %h expected %h", i, outs(), idle_v);
            end
        end
    endtask

    task automatic test_arith(input logic [1:0] opc, input logic [2:0] su,
                              input logic [3:0] a, input logic [3:0] b, input logic [3:0] exp_z);
        logic [17:0] e [5];
        e[0] = exp_v(K_LD,  K_HLD, K_HLD, U_PASS, 1'b0, 1'b1, 1'b0);
        e[1] = exp_v(K_HLD, K_LD,  K_HLD, U_PASS, 1'b1, 1'b1, 1'b0);
        e[2] = exp_v(K_HLD, K_HLD, K_LD,  su,     1'b0, 1'b1, 1'b0);
        e[3] = exp_v(K_HLD, K_HLD, K_HLD, U_PASS, 1'b0, 1'b1, 1'b1);
        e[4] = exp_v(K_HLD, K_HLD, K_HLD, U_PASS, 1'b0, 1'b0, 1'b0);
        operand_a = a;
        operand_b = b;
        bus.op = opc;
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            bus.start = 1'b0;
            n_compared++;
            if (outs() !== e[i]) begin
                n_mismatched++;
                $display("FAIL arith_op%0d_cycle%0d: got %h expected %h", opc, i + 1, outs(), e[i]);
            end
        end
        n_compared++;
        if (z_reg !== exp_z) begin
            n_mismatched++;
            $display("FAIL arith_op%0d_result: got %0d expected %0d", opc, z_reg, exp_z);
        end
    endtask

    task automatic test_popcnt();
        logic [3:0]  tz_exp [4];
        logic [17:0] e;
        tz_exp[0] = K_LD;
        tz_exp[1] = K_HLD;
        tz_exp[2] = K_LD;
        tz_exp[3] = K_LD;
        operand_a = 4'd7;
        operand_b = 4'b1101;
        bus.op = 2'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        e = exp_v(K_LD, K_HLD, K_HLD, U_PASS, 1'b0, 1'b1, 1'b0);
        n_compared++;
        if (outs() !== e) begin
            n_mismatched++;
            $display("FAIL popcnt_ldx: got %h expected %h", outs(), e);
        end
        step();
        e = exp_v(K_HLD, K_LD, K_HLD, U_PASS, 1'b1, 1'b1, 1'b0);
        n_compared++;
        if (outs() !== e) begin
            n_mismatched++;
            $display("FAIL popcnt_ldy: got %h expected %h", outs(), e);
        end
        step();
        e = exp_v(K_HLD, K_HLD, K_CLR, U_PASS, 1'b0, 1'b1, 1'b0);
        n_compared++;
        if (outs() !== e) begin
            n_mismatched++;
            $display("FAIL popcnt_clrz: got %h expected %h", outs(), e);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            e = exp_v(K_HLD, K_SHR, tz_exp[i], U_INC, 1'b0, 1'b1, 1'b0);
            n_compared++;
            if (outs() !== e) begin
                n_mismatched++;
                $display("FAIL popcnt_conta%0d: got %h expected %h", i, outs(), e);
            end
        end
        step();
        e = exp_v(K_HLD, K_HLD, K_HLD, U_PASS, 1'b0, 1'b1, 1'b1);
        n_compared++;
        if (outs() !== e) begin
            n_mismatched++;
            $display("FAIL popcnt_fim_cycle8: got %h expected %h", outs(), e);
        end
        n_compared++;
        if (z_reg !== 4'd3) begin
            n_mismatched++;
            $display("FAIL popcnt_result: got %0d expected 3", z_reg);
        end
        step();
        n_compared++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_mismatched++;
            $display("FAIL popcnt_idle: got busy/done %b expected 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_clrall();
        logic [17:0] e;
        bus.op = 2'd3;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        e = exp_v(K_CLR, K_CLR, K_CLR, U_PASS, 1'b0, 1'b1, 1'b0);
        n_compared++;
        if (outs() !== e) begin
            n_mismatched++;
            $display("FAIL clrall_clr: got %h expected %h", outs(), e);
        end
        step();
        e = exp_v(K_HLD, K_HLD, K_HLD, U_PASS, 1'b0, 1'b1, 1'b1);
        n_compared++;
        if (outs() !== e) begin
            n_mismatched++;
            $display("FAIL clrall_fim_cycle2: got %h expected %h", outs(), e);
        end
        n_compared++;
        if ({x_reg, y_reg, z_reg} !== 12'h000) begin
            n_mismatched++;
            $display("FAIL clrall_regs: got %h expected 000", {x_reg, y_reg, z_reg});
        end
        step();
    endtask

    task automatic test_back_to_back();
        int         dones;
        logic [2:0] exec_sel;
        dones = 0;
        exec_sel = 3'd7;
        operand_a = 4'd1;
        operand_b = 4'd2;
        bus.op = 2'd0;
        bus.start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.done === 1'b1) dones++;
            if (i == 0) bus.op = 2'd3;
            if (i == 2) exec_sel = bus.sel_ula;
            if (i == 3) bus.start = 1'b0;
        end
        n_compared++;
        if (dones != 1) begin
            n_mismatched++;
            $display("FAIL held_start_done_count: got %0d expected 1", dones);
        end
        n_compared++;
        if (exec_sel !== U_ADD) begin
            n_mismatched++;
            $display("FAIL held_start_latched_op: got %0d expected %0d", exec_sel, U_ADD);
        end
        n_compared++;
        if (bus.busy !== 1'b0) begin
            n_mismatched++;
            $display("FAIL held_start_idle: got busy %b expected 0", bus.busy);
        end
        n_compared++;
        if (z_reg !== 4'd3) begin
            n_mismatched++;
            $display("FAIL held_start_result: got %0d expected 3", z_reg);
        end
    endtask

    task automatic test_reset_mid();
        logic [17:0] idle_v;
        idle_v = exp_v(K_HLD, K_HLD, K_HLD, U_PASS, 1'b0, 1'b0, 1'b0);
        operand_b = 4'b1111;
        bus.op = 2'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_compared++;
        if (bus.Ty !== K_SHR) begin
            n_mismatched++;
            $display("FAIL reset_mid_in_conta: got Ty %0d expected %0d", bus.Ty, K_SHR);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_compared++;
        if (outs() !== idle_v) begin
            n_mismatched++;
            $display("FAIL reset_mid_idle: got %h expected %h", outs(), idle_v);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_compared++;
            if (outs() !== idle_v) begin
                n_mismatched++;
                $display("FAIL reset_mid_no_done[%0d]: got %h expected %h", i, outs(), idle_v);
            end
        end
    endtask

`ifdef CONTROLADOR_ABORT_EN
    task automatic test_abort();
        logic [17:0] e;
        bus.op = 2'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.abort = 1'b1;
        #1;
        e = exp_v(K_HLD, K_HLD, K_HLD, U_PASS, 1'b0, 1'b1, 1'b0);
        n_compared++;
        if ({outs(), bus.aborted} !== {e, 1'b1}) begin
            n_mismatched++;
            $display("FAIL abort_ldy: got %h expected %h", {outs(), bus.aborted}, {e, 1'b1});
        end
        step();
        bus.abort = 1'b0;
        #1;
        e = exp_v(K_HLD, K_HLD, K_HLD, U_PASS, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_compared++;
            if ({outs(), bus.aborted} !== {e, 1'b0}) begin
                n_mismatched++;
                $display("FAIL abort_idle[%0d]: got %h expected %h", i, {outs(), bus.aborted}, {e, 1'b0});
            end
            step();
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef CONTROLADOR_ABORT_EN
        bus.abort = 1'b0;
`endif
        test_reset();
        test_arith(2'd0, U_ADD, 4'd5, 4'd3, 4'd8);
        test_arith(2'd0, U_ADD, 4'd9, 4'd9, 4'd2);
        test_popcnt();
        test_clrall();
        test_back_to_back();
        test_reset_mid();
        test_arith(2'd1, U_SUB, 4'd3, 4'd5, 4'd14);
`ifdef CONTROLADOR_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/controlador_registradores.md
Name: controlador_registradores

Overview:
- Sequencing FSM that drives the 4-bit control codes of the X, Y and Z working registers, plus the ULA (ALU) operation select and operand-input select.
- Accepts one command per start pulse: ADD, SUB, POPCNT (count ones in Y using Y right-shifts), or CLRALL.
- Sits between the top-level command source and the register/ULA datapath; owns no data, only control.

Parameters:
- WIDTH, 4, datapath register width; sets the POPCNT iteration count.
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command request; sampled only in IDLE.
- op  in  2  command: 0=ADD, 1=SUB, 2=POPCNT, 3=CLRALL; latched on accepted start.
- y_lsb  in  1  Y[0] fed back from register Y.
- Tx  out  4  register X control code.
- Ty  out  4  register Y control code.
- Tz  out  4  register Z control code.
- sel_ula  out  3  ULA operation: 0=PASS_IN, 1=ADD (X+Y), 2=SUB (X-Y), 3=INC_Z (Z+1).
- sel_in  out  1  external operand mux select: 0=operand A, 1=operand B.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in FIM.

Behaviour:
- Register codes: CLEAR=0, HOLD=1, LOAD=2, SHFTR=3. Codes 4..15 are never driven.
- Outputs are a Moore decode of the state. Only exception: Tz in CONTA depends on y_lsb.
- Default for any output not listed for a state: Tx=Ty=Tz=HOLD, sel_ula=PASS_IN, sel_in=0, done=0.
- Reset (synchronous, takes effect at the next clock edge): state=IDLE, op latch=0, counter=0. Outputs: Tx=Ty=Tz=HOLD(1), sel_ula=0, sel_in=0, busy=0, done=0.
- Reset asserted mid-command: IDLE at the next edge; no done pulse; datapath contents left as they are.
- IDLE:
  - start=1 with op in 0..2 -> LDX; op=3 -> CLR.
  - start=0 -> stay in IDLE.
- LDX: Tx=LOAD, sel_ula=PASS_IN, sel_in=0 -> LDY.
- LDY: Ty=LOAD, sel_ula=PASS_IN, sel_in=1. Next: op=ADD/SUB -> EXEC; op=POPCNT -> CLRZ.
- EXEC: Tz=LOAD, sel_ula = ADD for op 0, SUB for op 1 -> FIM.
- CLRZ: Tz=CLEAR; counter<=0 -> CONTA.
- CONTA:
  - Ty=SHFTR, sel_ula=INC_Z.
  - Tz=LOAD if y_lsb else HOLD.
  - Counter increments each cycle; exits to FIM after exactly WIDTH cycles, i.e. in the cycle where counter==WIDTH-1.
- CLR: Tx=Ty=Tz=CLEAR -> FIM.
- FIM: done=1 -> IDLE.
- start while busy: ignored, not queued. start in the FIM cycle is also ignored.
- Latency from the start-accept edge to done high:
  - ADD/SUB: done in the 4th cycle.
  - POPCNT: done in the (WIDTH+4)th cycle.
  - CLRALL: done in the 2nd cycle.
- Arithmetic: SUB wraps modulo 2^WIDTH, performed in the ULA; the controller only selects it. POPCNT result lies in 0..WIDTH.
- Back-to-back: earliest next accept is the cycle after FIM.

Optional Feature:
- Macro: CONTROLADOR_ABORT_EN.
- With it defined:
  - Adds input abort (1) and output aborted (1, pulse).
  - abort=1 in any state other than IDLE/FIM -> IDLE at the next edge; outputs forced to HOLD that cycle; done not pulsed; aborted=1 for exactly that one cycle.
  - Priority: reset > abort > normal transition.
  - abort in IDLE or FIM has no effect.
- Without it: neither port exists and behaviour is exactly as above.

Decomposition:
- Package controlador_pkg:
  - register codes CLEAR/HOLD/LOAD/SHFTR;
  - ULA select codes PASS_IN/ADD/SUB/INC_Z;
  - op codes;
  - state enum IDLE, LDX, LDY, EXEC, CLRZ, CONTA, CLR, FIM.
- Sub-module contador_iteracoes:
  - clear / enable / terminal-count counter, WIDTH-parameterised;
  - asserts tc when count==WIDTH-1.
- FSM and output decode stay in the top module.

Test Plan:
- Reset held 2 cycles -> Tx=Ty=Tz=1, sel_ula=0, busy=0, done=0. Release, no start -> outputs unchanged for 10 cycles.
- start, op=0 -> sequence LDX (Tx=2, sel_in=0), LDY (Ty=2, sel_in=1), EXEC (Tz=2, sel_ula=1), FIM done=1; done seen in cycle 4; busy low afterwards.
- op=2 with WIDTH=4 and y_lsb stream 1,0,1,1 during CONTA -> Ty=3 for 4 cycles; Tz=2,1,2,2; sel_ula=3; done in cycle 8. With the ULA/register models attached, Y=4'b1101 yields Z=3.
- op=3 -> CLR cycle with Tx=Ty=Tz=0, then done in cycle 2. Also: start held high through a busy ADD -> exactly one command executed.
- reset asserted in the second CONTA cycle -> IDLE at the next edge, all codes HOLD, no done. A fresh op=1 then completes with sel_ula=2 in EXEC.
- CONTROLADOR_ABORT_EN defined: abort in LDY -> aborted pulse of 1 cycle, no done, IDLE next. Undefined: the build has no abort port.
